radix4_bfly_pipe: RTL and testbench
===================================

# radix4_bfly_pipe

Pipelined, parametrised radix-4 decimation-in-frequency butterfly for the FFT datapath. It accepts one set of four complex samples and three complex twiddles per beat and computes the 4-point DFT. Outputs 1..3 are multiplied by their twiddles, with runtime down-scaling, rounding and saturation applied. A valid/ready stream sits on each side, so the FFT stage controller can stall it. It replaces the combinational butterfly in every radix-4 stage of the 16-point FFT and scales to larger sizes.

## Interface
- DW, 16: sample width, signed two's complement, per real/imag part.
- TW, 16: twiddle width, signed Q1.(TW-1).
- SMAX, 2: maximum runtime right-shift; shift port is clog2(SMAX+1) bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- shift  in  clog2(SMAX+1)  right-shift for this beat; sampled with the data.
- a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i  in  DW each  input samples A..D.
- w1_r, w1_i, w2_r, w2_i, w3_r, w3_i  in  TW each  twiddles for outputs 1..3.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- y0_r, y0_i .. y3_r, y3_i  out  DW each  results.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- DFT, full precision (DW+2 bits):
  - X0 = A+B+C+D
  - X1 = A−jB−C+jD, so X1r = Ar+Bi−Cr−Di and X1i = Ai−Br−Ci+Dr
  - X2 = A−B+C−D
  - X3 = A+jB−C−jD
- Twiddle: Pk = Xk·Wk for k=1..3.
  - Pr = Xr·Wr − Xi·Wi and Pi = Xr·Wi + Xi·Wr.
  - Width DW+TW+3, no truncation before the final rounding.
- Final scaling uses a single rounding step, round-half-up: add 2^(n−1), then arithmetic shift right by n.
  - y0: n = shift.
  - y1..y3: n = TW−1+shift.
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1].
  - ovf sets on any clamped part of any accepted output beat.
  - ovf_clr clears ovf. If clear and set happen in the same cycle, set wins.
- shift > SMAX is treated as SMAX.
- W = 0x8000 denotes exactly −1. +1 is not representable; 0x7FFF is used instead.

## Timing
- Four register stages:
  - S1: input capture.
  - S2: DFT sums.
  - S3: complex products.
  - S4: round/scale/saturate, which is the output register.
- Latency: a beat accepted at edge N is presented on y* with out_valid=1 after edge N+3.
- Throughput: 1 beat/cycle when out_ready stays high.
- Pipeline enable: en = !out_valid || out_ready.
  - in_ready = en, combinational.
  - All stages advance only when en=1.
  - Internal bubbles are not collapsed; a valid bit travels with each stage.
- Output behaviour while stalled:
  - y* and out_valid hold stable while out_valid && !out_ready.
  - No beat is dropped, duplicated or reordered.
- Reset (rst_n low, at any time including mid-stream):
  - All stage valid bits go to 0, out_valid=0, y*=0, ovf=0, immediately.
  - In-flight beats are discarded.
  - in_ready=1 from the first cycle after rst_n deasserts.
- ovf updates on the edge that loads S4 with a valid beat.

## Structure
- Package fft_pkg holds:
  - DW/TW default constants.
  - Complex sample struct typedef.
  - Functions rnd_shift(value, n) and sat(value, DW).
- Sub-module fft_cmul: registered complex multiplier (DW+2)×TW, instantiated 3 times in S3.
- X0 is delay-matched through S3 with a plain register.

## Test plan
- Equal inputs: A=B=C=D=(100,0), all W=(32767,0), shift=0 → y0=(400,0), y1=y2=y3=(0,0), ovf=0.
- Impulse twiddle check: A=(1000,0), B=C=D=0, W1=(0,−32768), W2=(32767,0), W3=(−32768,0) → y0=(1000,0), y1=(0,−1000), y2=(1000,0), y3=(−1000,0).
- Rounding: shift=1, A=(3,−3), others 0 → y0=(2,−1).
- Saturation and sticky flag:
  - A=B=C=D=(32767,0), shift=0 → y0=(32767,0), ovf=1.
  - ovf stays 1 across following clean beats.
  - ovf_clr pulse → 0; ovf_clr coincident with a new saturating beat → ovf stays 1.
- Backpressure: stream 8 distinct beats, drop out_ready for 5 cycles mid-stream.
  - in_ready falls in the same cycle.
  - Outputs hold stable during the stall.
  - All 8 results arrive in order, each exactly once.
- Reset mid-flight: 3 beats in the pipe, pulse rst_n low for 1 cycle → out_valid=0 and y*=0 immediately; none of the 3 beats ever appears on the output.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and fixed-point helpers for the FFT datapath.
package fft_pkg;
  localparam int DW_DEF   = 16;
  localparam int TW_DEF   = 16;
  localparam int SMAX_DEF = 2;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  // 64-bit working width covers DW+TW+3 for every configuration we build
  function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v,
                                                   input int unsigned n);
    if (n == 0) return v;
    return (v + (64'sd1 <<< (n - 1))) >>> n;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/radix4_bfly_pipe_if.sv
// Stream bus of the radix-4 butterfly: input beat, output beat and overflow flag.
interface radix4_bfly_pipe_if #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int SMAX = 2
);
  localparam int SW = $clog2(SMAX + 1);

  logic          in_valid, in_ready;
  logic [SW-1:0] shift;
  logic [DW-1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
  logic [TW-1:0] w1_r, w1_i, w2_r, w2_i, w3_r, w3_i;
  logic          out_valid, out_ready;
  logic [DW-1:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
  logic          ovf, ovf_clr;

  modport master (
    output in_valid, shift, a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i,
           w1_r, w1_i, w2_r, w2_i, w3_r, w3_i, out_ready, ovf_clr,
    input  in_ready, out_valid, y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i, ovf
  );
  modport slave (
    input  in_valid, shift, a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i,
           w1_r, w1_i, w2_r, w2_i, w3_r, w3_i, out_ready, ovf_clr,
    output in_ready, out_valid, y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i, ovf
  );
endinterface

// File: rtl/fft_cmul.sv
// Registered complex multiplier (xr + j*xi) * (wr + j*wi), full-precision result.
module fft_cmul #(
  parameter int XW = 18,
  parameter int TW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic signed [XW-1:0]  xr,
  input  logic signed [XW-1:0]  xi,
  input  logic signed [TW-1:0]  wr,
  input  logic signed [TW-1:0]  wi,
  output logic signed [XW+TW:0] pr,
  output logic signed [XW+TW:0] pi
);
  localparam int PW = XW + TW + 1;

  logic signed [PW-1:0] xr_e, xi_e, wr_e, wi_e;
  assign xr_e = PW'(xr);
  assign xi_e = PW'(xi);
  assign wr_e = PW'(wr);
  assign wi_e = PW'(wi);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pr <= '0;
      pi <= '0;
    end else if (en) begin
      pr <= xr_e * wr_e - xi_e * wi_e;
      pi <= xr_e * wi_e + xi_e * wr_e;
    end
endmodule

// File: rtl/radix4_bfly_pipe.sv
// Four-stage radix-4 DIF butterfly: capture, DFT sums, twiddle products, round/scale/saturate.
module radix4_bfly_pipe import fft_pkg::*; #(
  parameter int DW   = DW_DEF,
  parameter int TW   = TW_DEF,
  parameter int SMAX = SMAX_DEF
) (
  input logic              clk,
  input logic              rst_n,
  radix4_bfly_pipe_if.slave bus
);
  localparam int STAGES = 4;
  localparam int SW     = $clog2(SMAX + 1);
  localparam int XW     = DW + 2;
  localparam int PW     = DW + TW + 3;

  logic              en;
  logic [STAGES:1]   vld_pipe;

  // whole pipe freezes while the output register holds an unaccepted beat
  assign en           = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};

  // S1: capture
  logic signed [DW-1:0] s1_r [4], s1_i [4];
  logic signed [TW-1:0] s1_wr [3], s1_wi [3];
  logic [SW-1:0]        s1_sh;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin s1_r[k] <= '0; s1_i[k] <= '0; end
      for (int k = 0; k < 3; k++) begin s1_wr[k] <= '0; s1_wi[k] <= '0; end
      s1_sh <= '0;
    end else if (en) begin
      s1_r[0] <= bus.a_r;  s1_i[0] <= bus.a_i;
      s1_r[1] <= bus.b_r;  s1_i[1] <= bus.b_i;
      s1_r[2] <= bus.c_r;  s1_i[2] <= bus.c_i;
      s1_r[3] <= bus.d_r;  s1_i[3] <= bus.d_i;
      s1_wr[0] <= bus.w1_r; s1_wi[0] <= bus.w1_i;
      s1_wr[1] <= bus.w2_r; s1_wi[1] <= bus.w2_i;
      s1_wr[2] <= bus.w3_r; s1_wi[2] <= bus.w3_i;
      s1_sh <= (bus.shift > SW'(SMAX)) ? SW'(SMAX) : bus.shift;
    end

  // S2: 4-point DFT at DW+2 bits, no growth lost
  logic signed [XW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [XW-1:0] x_r [4], x_i [4];
  assign ar = XW'(s1_r[0]); assign ai = XW'(s1_i[0]);
  assign br = XW'(s1_r[1]); assign bi = XW'(s1_i[1]);
  assign cr = XW'(s1_r[2]); assign ci = XW'(s1_i[2]);
  assign dr = XW'(s1_r[3]); assign di = XW'(s1_i[3]);

  always_comb begin
    x_r[0] = ar + br + cr + dr;  x_i[0] = ai + bi + ci + di;
    x_r[1] = ar + bi - cr - di;  x_i[1] = ai - br - ci + dr;
    x_r[2] = ar - br + cr - dr;  x_i[2] = ai - bi + ci - di;
    x_r[3] = ar - bi - cr + di;  x_i[3] = ai + br - ci - dr;
  end

  logic signed [XW-1:0] s2_r [4], s2_i [4];
  logic signed [TW-1:0] s2_wr [3], s2_wi [3];
  logic [SW-1:0]        s2_sh;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin s2_r[k] <= '0; s2_i[k] <= '0; end
      for (int k = 0; k < 3; k++) begin s2_wr[k] <= '0; s2_wi[k] <= '0; end
      s2_sh <= '0;
    end else if (en) begin
      s2_r <= x_r;   s2_i <= x_i;
      s2_wr <= s1_wr; s2_wi <= s1_wi;
      s2_sh <= s1_sh;
    end

  // S3: twiddle products; X0 rides alongside in a plain register
  logic signed [PW-1:0] p_r [3], p_i [3];
  logic signed [XW-1:0] s3_x0r, s3_x0i;
  logic [SW-1:0]        s3_sh;

  for (genvar k = 0; k < 3; k++) begin : g_cmul
    fft_cmul #(.XW(XW), .TW(TW)) u_cmul (
      .clk(clk), .rst_n(rst_n), .en(en),
      .xr(s2_r[k+1]), .xi(s2_i[k+1]), .wr(s2_wr[k]), .wi(s2_wi[k]),
      .pr(p_r[k]), .pi(p_i[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s3_x0r <= '0; s3_x0i <= '0; s3_sh <= '0;
    end else if (en) begin
      s3_x0r <= s2_r[0]; s3_x0i <= s2_i[0]; s3_sh <= s2_sh;
    end

  // S4: single rounding step; twiddled outputs also drop the Q1.(TW-1) fraction
  logic signed [63:0]     v_r [4], v_i [4], q_r [4], q_i [4], c_r [4], c_i [4];
  logic [3:0][DW-1:0]     yn_r, yn_i, y_r, y_i;
  logic                   clip, ovf_q;

  always_comb begin
    v_r[0] = 64'(s3_x0r);
    v_i[0] = 64'(s3_x0i);
    for (int k = 1; k < 4; k++) begin
      v_r[k] = 64'(p_r[k-1]);
      v_i[k] = 64'(p_i[k-1]);
    end
  end

  always_comb begin
    clip = 1'b0;
    yn_r = '0;
    yn_i = '0;
    for (int k = 0; k < 4; k++) begin
      q_r[k] = rnd_shift(v_r[k], (k == 0) ? 32'(s3_sh) : 32'(s3_sh) + 32'(TW - 1));
      q_i[k] = rnd_shift(v_i[k], (k == 0) ? 32'(s3_sh) : 32'(s3_sh) + 32'(TW - 1));
      c_r[k] = sat(q_r[k], DW);
      c_i[k] = sat(q_i[k], DW);
      clip   = clip | (c_r[k] != q_r[k]) | (c_i[k] != q_i[k]);
      yn_r[k] = c_r[k][DW-1:0];
      yn_i[k] = c_i[k][DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_r <= '0;
      y_i <= '0;
    end else if (en) begin
      y_r <= yn_r;
      y_i <= yn_i;
    end

  // a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          ovf_q <= 1'b0;
    else if (en && vld_pipe[3] && clip)  ovf_q <= 1'b1;
    else if (bus.ovf_clr)                ovf_q <= 1'b0;

  assign bus.ovf  = ovf_q;
  assign bus.y0_r = y_r[0]; assign bus.y0_i = y_i[0];
  assign bus.y1_r = y_r[1]; assign bus.y1_i = y_i[1];
  assign bus.y2_r = y_r[2]; assign bus.y2_i = y_i[2];
  assign bus.y3_r = y_r[3]; assign bus.y3_i = y_i[3];
endmodule

// File: tb/tb_radix4_bfly_pipe.sv
// Bench for radix4_bfly_pipe: directed cases and randomized streams scored against an arithmetic model.
module tb_radix4_bfly_pipe;
  import fft_pkg::*;

  localparam int DW = 16, TW = 16, SMAX = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  radix4_bfly_pipe_if #(.DW(DW), .TW(TW), .SMAX(SMAX)) bus();
  radix4_bfly_pipe #(.DW(DW), .TW(TW), .SMAX(SMAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, failures = 0;

  typedef struct packed {
    cplx_t a, b, c, d, w1, w2, w3;
    logic [1:0] sh;
  } beat_t;

  typedef struct packed {
    cplx_t [3:0] y;
    logic        clip;
  } res_t;

  function automatic cplx_t cx(input int r, input int i);
    cplx_t z;
    z.re = 16'(r);
    z.im = 16'(i);
    return z;
  endfunction

  function automatic longint rnd(input longint v, input int n);
    if (n == 0) return v;
    return (v + (longint'(1) <<< (n - 1))) >>> n;
  endfunction

  // reference: DFT, twiddle, round-half-up, clamp, all in 64-bit integers
  function automatic res_t model(input beat_t b);
    longint xr[4], xi[4], wr[4], wi[4];
    longint ar, ai, br, bi, cr, ci, dr, di, vr, vi, hi, lo;
    int s, n;
    res_t r;
    ar = longint'(b.a.re); ai = longint'(b.a.im);
    br = longint'(b.b.re); bi = longint'(b.b.im);
    cr = longint'(b.c.re); ci = longint'(b.c.im);
    dr = longint'(b.d.re); di = longint'(b.d.im);
    wr[0] = 0; wi[0] = 0;
    wr[1] = longint'(b.w1.re); wi[1] = longint'(b.w1.im);
    wr[2] = longint'(b.w2.re); wi[2] = longint'(b.w2.im);
    wr[3] = longint'(b.w3.re); wi[3] = longint'(b.w3.im);
    s = (int'(b.sh) > SMAX) ? SMAX : int'(b.sh);
    xr[0] = ar + br + cr + dr;  xi[0] = ai + bi + ci + di;
    xr[1] = ar + bi - cr - di;  xi[1] = ai - br - ci + dr;
    xr[2] = ar - br + cr - dr;  xi[2] = ai - bi + ci - di;
    xr[3] = ar - bi - cr + di;  xi[3] = ai + br - ci - dr;
    hi = 2**(DW-1) - 1;
    lo = -(2**(DW-1));
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        vr = xr[0]; vi = xi[0]; n = s;
      end else begin
        vr = xr[k] * wr[k] - xi[k] * wi[k];
        vi = xr[k] * wi[k] + xi[k] * wr[k];
        n  = TW - 1 + s;
      end
      vr = rnd(vr, n);
      vi = rnd(vi, n);
      if (vr > hi || vr < lo || vi > hi || vi < lo) r.clip = 1'b1;
      vr = (vr > hi) ? hi : ((vr < lo) ? lo : vr);
      vi = (vi > hi) ? hi : ((vi < lo) ? lo : vi);
      r.y[k] = cx(int'(vr), int'(vi));
    end
    return r;
  endfunction

  function automatic beat_t rbeat();
    beat_t b;
    b.a = cplx_t'($urandom);  b.b = cplx_t'($urandom);
    b.c = cplx_t'($urandom);  b.d = cplx_t'($urandom);
    b.w1 = cplx_t'($urandom); b.w2 = cplx_t'($urandom); b.w3 = cplx_t'($urandom);
    b.sh = 2'($urandom_range(0, 3));
    return b;
  endfunction

  function automatic beat_t mk(input cplx_t a, b, c, d, w1, w2, w3, input int sh);
    beat_t r;
    r.a = a; r.b = b; r.c = c; r.d = d;
    r.w1 = w1; r.w2 = w2; r.w3 = w3;
    r.sh = 2'(sh);
    return r;
  endfunction

  function automatic res_t grab();
    res_t r;
    r = '0;
    r.y[0] = {bus.y0_r, bus.y0_i};
    r.y[1] = {bus.y1_r, bus.y1_i};
    r.y[2] = {bus.y2_r, bus.y2_i};
    r.y[3] = {bus.y3_r, bus.y3_i};
    return r;
  endfunction

  task automatic drive(input beat_t b);
    bus.a_r = b.a.re;  bus.a_i = b.a.im;  bus.b_r = b.b.re;  bus.b_i = b.b.im;
    bus.c_r = b.c.re;  bus.c_i = b.c.im;  bus.d_r = b.d.re;  bus.d_i = b.d.im;
    bus.w1_r = b.w1.re; bus.w1_i = b.w1.im;
    bus.w2_r = b.w2.re; bus.w2_i = b.w2.im;
    bus.w3_r = b.w3.re; bus.w3_i = b.w3.im;
    bus.shift = b.sh;
  endtask

  // one beat through an idle pipe; optionally pulses ovf_clr on the edge that loads S4
  task automatic run_one(input beat_t b, input bit clr_at_load, output res_t got,
                         output logic ovf, output int lat);
    @(negedge clk);
    drive(b);
    bus.in_valid = 1'b1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.ovf_clr  = clr_at_load && (i == 2);
      if (bus.out_valid) begin lat = i; break; end
    end
    bus.ovf_clr = 1'b0;
    got = grab();
    ovf = bus.ovf;
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL latency: got %0d cycles, expected 3", lat);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;
    drive('0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || grab() !== res_t'(0)) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b ovf=%b y=%h, expected 0/0/0",
               bus.out_valid, bus.ovf, grab());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_equal();
    beat_t b; res_t got, e; logic o; int lat;
    b = mk(cx(100,0), cx(100,0), cx(100,0), cx(100,0), cx(32767,0), cx(32767,0), cx(32767,0), 0);
    run_one(b, 1'b0, got, o, lat);
    e = '0;
    e.y[0] = cx(400, 0);
    checks++;
    if (got.y !== e.y || o !== 1'b0) begin
      failures++;
      $display("FAIL equal_inputs: y=%h ovf=%b, expected y=%h ovf=0", got.y, o, e.y);
    end
  endtask

  task automatic test_impulse();
    beat_t b; res_t got, e; logic o; int lat;
    b = mk(cx(1000,0), cx(0,0), cx(0,0), cx(0,0), cx(0,-32768), cx(32767,0), cx(-32768,0), 0);
    run_one(b, 1'b0, got, o, lat);
    e = '0;
    e.y[0] = cx(1000, 0); e.y[1] = cx(0, -1000);
    e.y[2] = cx(1000, 0); e.y[3] = cx(-1000, 0);
    checks++;
    if (got.y !== e.y) begin
      failures++;
      $display("FAIL impulse_twiddle: y=%h, expected %h", got.y, e.y);
    end
  endtask

  task automatic test_rounding();
    beat_t b; res_t got, e; logic o; int lat;
    b = mk(cx(3,-3), cx(0,0), cx(0,0), cx(0,0), cx(32767,0), cx(32767,0), cx(32767,0), 1);
    run_one(b, 1'b0, got, o, lat);
    checks++;
    if (got.y[0] !== cx(2, -1)) begin
      failures++;
      $display("FAIL rounding_y0: y0=%h, expected %h", got.y[0], cx(2, -1));
    end
    e = model(b);
    checks++;
    if (got.y !== e.y) begin
      failures++;
      $display("FAIL rounding_all: y=%h, expected %h", got.y, e.y);
    end
  endtask

  task automatic test_saturation();
    beat_t bs, bc; res_t got; logic o; int lat;
    bs = mk(cx(32767,0), cx(32767,0), cx(32767,0), cx(32767,0), cx(32767,0), cx(32767,0), cx(32767,0), 0);
    bc = mk(cx(5,6), cx(-7,8), cx(9,-10), cx(11,12), cx(16384,0), cx(0,16384), cx(-16384,0), 2);
    run_one(bs, 1'b0, got, o, lat);
    checks++;
    if (got.y[0] !== cx(32767, 0) || o !== 1'b1) begin
      failures++;
      $display("FAIL sat_set: y0=%h ovf=%b, expected %h ovf=1", got.y[0], o, cx(32767, 0));
    end
    run_one(bc, 1'b0, got, o, lat);
    checks++;
    if (o !== 1'b1 || got.y !== model(bc).y) begin
      failures++;
      $display("FAIL sat_sticky: ovf=%b y=%h, expected ovf=1 y=%h", o, got.y, model(bc).y);
    end
    @(negedge clk) bus.ovf_clr = 1'b1;
    @(negedge clk) bus.ovf_clr = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear: ovf=%b, expected 0", bus.ovf);
    end
    run_one(bs, 1'b1, got, o, lat);
    checks++;
    if (o !== 1'b1) begin
      failures++;
      $display("FAIL sat_set_wins: ovf=%b, expected 1", o);
    end
    @(negedge clk) bus.ovf_clr = 1'b1;
    @(negedge clk) bus.ovf_clr = 1'b0;
  endtask

  // streams beats with a scoreboard; either random ready/gaps or one fixed stall window
  task automatic stream(input int nbeats, input bit rnd_mode, input int st0, input int stlen);
    res_t q[$];
    res_t e, held;
    beat_t b;
    bit pending = 1'b0, hold_chk = 1'b0;
    int sent = 0, recv = 0, cyc = 0;
    b = '0;
    held = '0;
    while ((sent < nbeats || q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      if (hold_chk) begin
        checks++;
        if (bus.out_valid !== 1'b1 || grab() !== held) begin
          failures++;
          $display("FAIL stall_hold: out_valid=%b y=%h, expected 1 y=%h", bus.out_valid, grab().y, held.y);
        end
      end
      bus.out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : !(cyc >= st0 && cyc < st0 + stlen);
      if (!pending && sent < nbeats && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
        b = rbeat();
        pending = 1'b1;
      end
      if (pending) drive(b);
      bus.in_valid = pending;
      #1;
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        failures++;
        $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b", bus.in_ready, bus.out_valid, bus.out_ready);
      end
      if (!rnd_mode && cyc == st0) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: got %b, expected 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat: y=%h, expected no output", grab().y);
        end else begin
          e = q.pop_front();
          recv++;
          if (grab().y !== e.y) begin
            failures++;
            $display("FAIL stream_data: beat %0d y=%h, expected %h", recv, grab().y, e.y);
          end
        end
      end
      hold_chk = bus.out_valid && !bus.out_ready;
      held = grab();
      if (pending && bus.in_ready) begin
        q.push_back(model(b));
        sent++;
        pending = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (recv != nbeats) begin
      failures++;
      $display("FAIL stream_count: received %0d, expected %0d", recv, nbeats);
    end
  endtask

  task automatic test_backpressure();
    stream(8, 1'b0, 5, 5);
  endtask

  task automatic test_back_to_back();
    stream(60, 1'b1, 0, 0);
  endtask

  task automatic test_reset_midflight();
    beat_t bs;
    bit seen = 1'b0;
    bs = mk(cx(32767,0), cx(32767,0), cx(32767,0), cx(32767,0), cx(1,0), cx(1,0), cx(1,0), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i == 0 ? bs : rbeat());
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1) begin
      failures++;
      $display("FAIL midflight_pre: out_valid=%b ovf=%b, expected 1/1", bus.out_valid, bus.ovf);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || grab() !== res_t'(0)) begin
      failures++;
      $display("FAIL midflight_reset: out_valid=%b ovf=%b y=%h, expected 0/0/0",
               bus.out_valid, bus.ovf, grab().y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midflight_in_ready: got %b, expected 1", bus.in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midflight_discard: a flushed beat appeared on the output");
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_impulse();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
